// File: rtl/udp_tx_feeder.sv
// udp_tx_feeder: buffers application bytes and cuts them into UDP payloads for the UDP transmit path.
// Latency: trigger to udp_tx_en >= 2 cycles; udp_tx_data is registered, 1 cycle after udp_tx_req.
// Backpressure: din_rdy drops when the circular buffer is full; ARM waits on tx_rdy indefinitely.
// Optional feature: define UDP_FEED_TIMEOUT_EN to flush partial frames after TIMEOUT_CYC idle cycles.
module udp_tx_feeder #(
   parameter int          ADDR_W      = 11,
   parameter logic [15:0] FRAME_LEN   = 16'd1024,
   parameter int          TIMEOUT_CYC = 125000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  din,
   input  logic        din_vld,
   output logic        din_rdy,
   input  logic        tx_rdy,
   input  logic        udp_tx_req,
   output logic        udp_tx_en,
   output logic [7:0]  udp_tx_data,
   output logic [15:0] udp_tx_data_num,
   output logic        busy,
   output logic [15:0] frame_cnt
);

   localparam int          DEPTH     = 1 << ADDR_W;
   localparam logic [16:0] FRAME_EXT = {1'b0, FRAME_LEN};

   typedef enum logic [2:0] {IDLE, ARM, START, SEND, DONE} state_t;

   state_t            state;
   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wp;
   logic [ADDR_W-1:0] rp;
   logic [ADDR_W:0]   fill;
   logic [ADDR_W:0]   fill_nxt;
   logic [16:0]       fill_ext;
   logic [15:0]       len;
   logic [15:0]       sent;
   logic              accept;
   logic              pop;
   logic              full_trig;
   logic              flush;

   assign accept    = din_vld & din_rdy;
   assign pop       = (state == SEND) & udp_tx_req & (sent < len);
   assign fill_ext  = 17'(fill);
   assign full_trig = (fill_ext >= FRAME_EXT);

`ifdef UDP_FEED_TIMEOUT_EN
   logic [31:0] idle_cnt;

   // A partial frame is flushed once the buffer has sat idle, non-empty, for TIMEOUT_CYC cycles.
   assign flush = (state == IDLE) && (fill != '0) && !full_trig &&
                  (idle_cnt == 32'(TIMEOUT_CYC - 1));

   // Idle counter: restarts on every accepted byte and on a flush; advances only in IDLE with data held.
   always_ff @(posedge clk) begin
      if (rst) begin
         idle_cnt <= '0;
      end else if (accept || flush) begin
         idle_cnt <= '0;
      end else if ((state == IDLE) && (fill != '0)) begin
         idle_cnt <= idle_cnt + 32'd1;
      end
   end
`else
   assign flush = 1'b0;
`endif

   // Fill count follows accepts and pops; a simultaneous accept and pop cancels out.
   always_comb begin
      fill_nxt = fill;
      if (accept && !pop) begin
         fill_nxt = fill + 1'b1;
      end else if (pop && !accept) begin
         fill_nxt = fill - 1'b1;
      end
   end

   // Byte store: written on accept; contents need no reset since fill/pointers gate all reads.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem[wp] <= din;
      end
   end

   // Pointers, flow control, frame FSM and all registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         wp              <= '0;
         rp              <= '0;
         fill            <= '0;
         din_rdy         <= 1'b0;
         len             <= '0;
         sent            <= '0;
         udp_tx_en       <= 1'b0;
         udp_tx_data     <= 8'h00;
         udp_tx_data_num <= '0;
         busy            <= 1'b0;
         frame_cnt       <= '0;
      end else begin
         fill        <= fill_nxt;
         // fill never exceeds DEPTH, so "fill < DEPTH" is simply the top bit clear.
         din_rdy     <= ~fill_nxt[ADDR_W];
         udp_tx_en   <= 1'b0;
         udp_tx_data <= pop ? mem[rp] : 8'h00;
         if (accept) begin
            wp <= wp + 1'b1;
         end
         if (pop) begin
            rp   <= rp + 1'b1;
            sent <= sent + 16'd1;
         end
         case (state)
            IDLE: begin
               if (full_trig) begin
                  len   <= FRAME_LEN;
                  state <= ARM;
                  busy  <= 1'b1;
               end else if (flush) begin
                  len   <= 16'(fill);
                  state <= ARM;
                  busy  <= 1'b1;
               end
            end
            ARM: begin
               if (tx_rdy) begin
                  state           <= START;
                  udp_tx_en       <= 1'b1;
                  udp_tx_data_num <= len;
                  frame_cnt       <= frame_cnt + 16'd1;
                  sent            <= '0;
               end
            end
            START: begin
               state <= SEND;
            end
            SEND: begin
               if (pop && ((sent + 16'd1) == len)) begin
                  state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_udp_tx_feeder.sv
// Bench for udp_tx_feeder: directed steps plus a randomized phase against a queue-based reference model.
// Configuration: ADDR_W=3 (8-byte buffer), FRAME_LEN=4, TIMEOUT_CYC=20; expectations follow UDP_FEED_TIMEOUT_EN.
// Outputs are sampled 1 time unit after each rising edge; inputs change only at those points.
module tb_udp_tx_feeder;

   localparam int DEPTH = 8;
   localparam int FLEN  = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  din = 8'h00;
   logic        din_vld = 1'b0;
   logic        din_rdy;
   logic        tx_rdy = 1'b0;
   logic        udp_tx_req = 1'b0;
   logic        udp_tx_en;
   logic [7:0]  udp_tx_data;
   logic [15:0] udp_tx_data_num;
   logic        busy;
   logic [15:0] frame_cnt;

   udp_tx_feeder #(.ADDR_W(3), .FRAME_LEN(16'd4), .TIMEOUT_CYC(20)) dut (
      .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .din_rdy(din_rdy),
      .tx_rdy(tx_rdy), .udp_tx_req(udp_tx_req), .udp_tx_en(udp_tx_en),
      .udp_tx_data(udp_tx_data), .udp_tx_data_num(udp_tx_data_num),
      .busy(busy), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: bytes held in the buffer, and the frame being served.
   logic [7:0]  q[$];
   logic [7:0]  out_log[$];
   bit          m_send = 0;
   bit          m_started = 0;
   int          m_rem = 0;
   logic [15:0] m_num = 0;
   logic [15:0] m_frames = 0;
   int          cyc = 0;
   int          en_cyc = -1;
   bit          last_acc = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: capture handshake before the edge, then update the model and check after it.
   task automatic tick();
      bit          rst_pre;
      bit          acc;
      bit          honored;
      logic [7:0]  byte_in;
      logic [7:0]  exp_d;
      rst_pre = rst;
      acc     = din_vld && din_rdy;
      byte_in = din;
      honored = m_send && udp_tx_req && (m_rem > 0);
      @(posedge clk);
      #1;
      cyc++;
      last_acc = acc && !rst_pre;
      if (rst_pre) begin
         q.delete();
         m_send = 0; m_started = 0; m_rem = 0; m_num = 0; m_frames = 0;
         chk("rst_en", udp_tx_en, 0);
         chk("rst_data", udp_tx_data, 0);
         chk("rst_num", udp_tx_data_num, 0);
         chk("rst_busy", busy, 0);
         chk("rst_fcnt", frame_cnt, 0);
         chk("rst_din_rdy", din_rdy, 0);
         return;
      end
      if (acc) q.push_back(byte_in);
      exp_d = 8'h00;
      if (honored) begin
         if (q.size() == 0) begin
            chk("pop_underflow", 1, 0);
         end else begin
            exp_d = q.pop_front();
            out_log.push_back(exp_d);
         end
         m_rem--;
      end
      chk("data", udp_tx_data, exp_d);
      if (m_send && m_rem == 0) m_send = 0;
      if (m_started) begin m_send = 1; m_started = 0; end
      chk("en_in_frame", udp_tx_en && m_send, 0);
      if (udp_tx_en) begin
         m_num = udp_tx_data_num;
         m_rem = udp_tx_data_num;
         m_started = 1;
         m_frames++;
         en_cyc = cyc;
`ifdef UDP_FEED_TIMEOUT_EN
         chk("num_range", (udp_tx_data_num >= 1) && (udp_tx_data_num <= FLEN), 1);
`else
         chk("num_full", udp_tx_data_num, FLEN);
`endif
         chk("num_le_fill", q.size() >= udp_tx_data_num, 1);
      end
      if (m_send || m_started) chk("busy_frame", busy, 1);
      chk("num_hold", udp_tx_data_num, m_num);
      chk("fcnt", frame_cnt, m_frames);
      chk("din_rdy", din_rdy, q.size() < DEPTH);
   endtask

   task automatic put_byte(input logic [7:0] b);
      din = b;
      din_vld = 1'b1;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (last_acc) break;
      end
      chk("put_accepted", last_acc, 1);
      din_vld = 1'b0;
   endtask

   initial begin
      int acc_cnt;
      int acc_cyc;
      int f0;
      logic [7:0] d5 [5];

      // Reset and release: din_rdy rises on the first edge after rst falls.
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("rdy_after_rst", din_rdy, 1);

      // Basic frame: four bytes, transmitter ready, continuous requests.
      out_log.delete();
      tx_rdy = 1'b1;
      udp_tx_req = 1'b1;
      put_byte(8'h11); put_byte(8'h22); put_byte(8'h33); put_byte(8'h44);
      repeat (15) tick();
      chk("t1_fcnt", frame_cnt, 1);
      chk("t1_num", udp_tx_data_num, 4);
      chk("t1_nbytes", out_log.size(), 4);
      if (out_log.size() == 4) begin
         chk("t1_b0", out_log[0], 8'h11);
         chk("t1_b1", out_log[1], 8'h22);
         chk("t1_b2", out_log[2], 8'h33);
         chk("t1_b3", out_log[3], 8'h44);
      end

      // Held in ARM while the transmitter is busy, then exactly five requests for a 4-byte frame.
      out_log.delete();
      udp_tx_req = 1'b0;
      tx_rdy = 1'b0;
      put_byte(8'hC1); put_byte(8'hC2); put_byte(8'hC3); put_byte(8'hC4);
      for (int i = 0; i < 50; i++) begin
         tick();
         chk("arm_no_en", udp_tx_en, 0);
      end
      chk("arm_busy", busy, 1);
      tx_rdy = 1'b1;
      tick();
      chk("arm_en", udp_tx_en, 1);
      chk("arm_num", udp_tx_data_num, 4);
      tick();
      udp_tx_req = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         d5[k] = udp_tx_data;
      end
      udp_tx_req = 1'b0;
      chk("req5_b0", d5[0], 8'hC1);
      chk("req5_b3", d5[3], 8'hC4);
      chk("req5_extra", d5[4], 8'h00);
      udp_tx_req = 1'b1;
      put_byte(8'hD1); put_byte(8'hD2); put_byte(8'hD3); put_byte(8'hD4);
      repeat (15) tick();
      chk("next_nbytes", out_log.size(), 8);
      if (out_log.size() == 8) begin
         chk("next_b0", out_log[4], 8'hD1);
         chk("next_b3", out_log[7], 8'hD4);
      end
      chk("t3_fcnt", frame_cnt, 3);

      // Buffer full: 12 bytes offered with no transmission; only 8 fit until draining starts.
      out_log.delete();
      tx_rdy = 1'b0;
      udp_tx_req = 1'b0;
      acc_cnt = 0;
      din = 8'hA0;
      din_vld = 1'b1;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (last_acc) begin acc_cnt++; din = 8'hA0 + 8'(acc_cnt); end
      end
      chk("full_acc", acc_cnt, 8);
      chk("full_rdy", din_rdy, 0);
      tx_rdy = 1'b1;
      udp_tx_req = 1'b1;
      for (int i = 0; i < 80; i++) begin
         tick();
         if (last_acc) begin
            acc_cnt++;
            if (acc_cnt == 12) din_vld = 1'b0;
            else din = 8'hA0 + 8'(acc_cnt);
         end
      end
      din_vld = 1'b0;
      chk("full_acc_all", acc_cnt, 12);
      chk("full_nbytes", out_log.size(), 12);
      if (out_log.size() == 12) begin
         for (int i = 0; i < 12; i++) chk("full_order", out_log[i], 8'hA0 + 8'(i));
      end

      // Partial tail: three bytes then idle.
      out_log.delete();
      f0 = m_frames;
      put_byte(8'hE1); put_byte(8'hE2); put_byte(8'hE3);
      acc_cyc = cyc;
      repeat (40) tick();
`ifdef UDP_FEED_TIMEOUT_EN
      chk("to_frames", m_frames, f0 + 1);
      chk("to_latency", ((en_cyc - acc_cyc) >= 21) && ((en_cyc - acc_cyc) <= 22), 1);
      chk("to_num", udp_tx_data_num, 3);
      chk("to_nbytes", out_log.size(), 3);
`else
      chk("tail_frames", m_frames, f0);
      chk("tail_nbytes", out_log.size(), 0);
      chk("tail_idle", busy, 0);
      put_byte(8'hE4);
      repeat (15) tick();
      chk("tail_num", udp_tx_data_num, 4);
      chk("tail_nbytes2", out_log.size(), 4);
`endif

      // Randomized traffic checked by the model on every cycle.
      din_vld = 1'b0;
      for (int i = 0; i < 2500; i++) begin
         if (!din_vld || last_acc) begin
            din_vld = 1'($urandom_range(0, 1));
            din = 8'($urandom);
         end
         tx_rdy = ($urandom_range(0, 3) != 0);
         udp_tx_req = 1'($urandom_range(0, 1));
         tick();
      end
      din_vld = 1'b0;
      udp_tx_req = 1'b0;

      // Reset in the middle of a frame, after two of four bytes.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      out_log.delete();
      tx_rdy = 1'b1;
      put_byte(8'hF1); put_byte(8'hF2); put_byte(8'hF3); put_byte(8'hF4);
      for (int i = 0; i < 10; i++) begin
         if (m_frames != 0) break;
         tick();
      end
      chk("mid_started", m_frames, 1);
      tick();
      udp_tx_req = 1'b1;
      repeat (2) tick();
      chk("mid_two", out_log.size(), 2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (10) tick();
      chk("mid_no_more", out_log.size(), 2);
      chk("mid_fcnt", frame_cnt, 0);
      chk("mid_empty_rdy", din_rdy, 1);
      chk("mid_busy", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/udp_tx_feeder.md
# udp_tx_feeder

User-side source for the UDP transmit interface of the Ethernet top level, running in the `gmii_tx_clk` domain. It buffers a byte stream from application logic and cuts it into UDP payloads. It then drives `udp_tx_en` / `udp_tx_data_num` and answers each `udp_tx_req` with one payload byte on the following cycle. It is the requester-facing counterpart of the UDP transmit path.

## Interface
- `ADDR_W`, 11: buffer address width; depth = 2^ADDR_W bytes.
- `FRAME_LEN`, 16'd1024: payload bytes per full frame; legal range 1 ≤ FRAME_LEN ≤ 2^ADDR_W.
- `TIMEOUT_CYC`, 125000: idle cycles before a partial frame is flushed; only used with the timeout feature.

Ports:
- `clk`  in  1  single clock; connect to `gmii_tx_clk`.
- `rst`  in  1  synchronous reset, active-high.
- `din`  in  8  application byte.
- `din_vld`  in  1  `din` valid; the byte is accepted when `din_vld & din_rdy`.
- `din_rdy`  out  1  buffer not full, registered.
- `tx_rdy`  in  1  Ethernet transmitter idle.
- `udp_tx_req`  in  1  transmitter requests the next payload byte.
- `udp_tx_en`  out  1  one-cycle frame start pulse.
- `udp_tx_data`  out  8  payload byte, valid 1 cycle after `udp_tx_req`.
- `udp_tx_data_num`  out  16  payload length of the current frame.
- `busy`  out  1  a frame is committed or in flight.
- `frame_cnt`  out  16  frames started since reset; wraps at 16'hFFFF→0.

## Operation
- Buffer: circular byte store with write pointer `wp`, read pointer `rp`, and fill count `fill` (ADDR_W+1 bits).
  - Simultaneous accept and read leaves `fill` unchanged.
  - Pointers wrap modulo 2^ADDR_W.
- `din_rdy` = (`fill` < 2^ADDR_W), registered. It accounts for the same-cycle accept/read so that no byte is ever dropped or overwritten.
- FSM states: IDLE, ARM, START, SEND, DONE.
  - IDLE → ARM when `fill` ≥ FRAME_LEN; latch `len` = FRAME_LEN.
  - IDLE → ARM on timeout (see Configuration); latch `len` = `fill`.
  - ARM → START when `tx_rdy` = 1. If `tx_rdy` stays 0, remain in ARM indefinitely.
  - START: drive `udp_tx_en` = 1 for exactly this cycle, load `udp_tx_data_num` = `len`, increment `frame_cnt`, clear `sent`, go to SEND.
  - SEND: each cycle with `udp_tx_req` = 1 and `sent` < `len` pops one byte and increments `sent`. When `sent` reaches `len`, go to DONE.
  - DONE → IDLE after 1 cycle; this guarantees a gap between frames.
- `udp_tx_req` outside SEND, or beyond `len` requests, is ignored: no pop, and `udp_tx_data` = 8'h00 on the next cycle.
- `busy` = 1 in ARM, START, SEND, and DONE.
- `udp_tx_data_num` holds its value until the next START.
- Bytes accepted during ARM or SEND belong to later frames; the length latched at the trigger is never changed.

## Timing
- Reset values (`rst` high at a rising edge): `udp_tx_en` 0, `udp_tx_data` 8'h00, `udp_tx_data_num` 0, `busy` 0, `frame_cnt` 0, `din_rdy` 0, `fill` 0, pointers 0, state IDLE.
  - `din_rdy` rises to 1 on the first edge after `rst` falls.
- Reset asserted mid-frame aborts the frame immediately and discards all buffered bytes.
- Trigger to `udp_tx_en` latency: 2 cycles minimum (IDLE→ARM, then ARM→START if `tx_rdy` is already high).
- `udp_tx_data` is registered: a request at cycle n gives data at cycle n+1. Back-to-back requests give back-to-back bytes.
- Trigger evaluation is suppressed while `busy`; the full-threshold check resumes the cycle after DONE.

## Configuration
- `UDP_FEED_TIMEOUT_EN` defined:
  - An idle counter clears on every accepted byte and counts only while state = IDLE and `fill` > 0.
  - When the counter reaches TIMEOUT_CYC−1 with 0 < `fill` < FRAME_LEN, the FSM triggers a flush with `len` = `fill`, and the counter clears.
- Not defined: the counter is not built, frames are sent only when `fill` ≥ FRAME_LEN, and a partial tail remains buffered indefinitely.

## Test plan
- FRAME_LEN = 4; write 8'h11, 22, 33, 44; hold `tx_rdy` = 1 and answer requests continuously → one `udp_tx_en` pulse with `udp_tx_data_num` = 4; `udp_tx_data` = 11, 22, 33, 44, each one cycle after its request; `frame_cnt` = 1.
- Trigger with `tx_rdy` held 0 for 50 cycles → `busy` = 1 and `udp_tx_en` stays 0; `udp_tx_en` pulses the cycle after `tx_rdy` rises.
- ADDR_W = 3; write 10 bytes with no transmission → `din_rdy` drops after the 8th accept; the 9th and 10th bytes are held by the source, and none are lost once draining starts.
- Send 5 requests for a frame with `len` = 4 → 4 pops; the fifth response is 8'h00; the next frame starts from the correct byte.
- With `UDP_FEED_TIMEOUT_EN`, TIMEOUT_CYC = 20, FRAME_LEN = 16; write 3 bytes then idle → `udp_tx_en` fires with `udp_tx_data_num` = 3 after 20 idle cycles plus the ARM/START latency. Without the macro, no frame is sent.
- Assert `rst` during SEND after 2 of 4 bytes → all outputs take reset values on the next edge, `fill` = 0, and no further bytes are emitted.
